// File: rtl/ysyx_22041412_csr_pkg.sv
// Shared constants for the machine-mode CSR file: CSR addresses, trap
// cause codes, request-kind encoding, writable-bit masks and the Zicsr
// read-modify-write helper.
package ysyx_22041412_csr_pkg;

  localparam int KIND_W = 2;

  // Full 12-bit CSR addresses.
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // Trap cause codes (the interrupt flag is added by the CSR file).
  localparam logic [6:0] CAUSE_ECALL_M = 7'd11;
  localparam logic [6:0] CAUSE_MTIMER  = 7'd7;

  typedef enum logic [KIND_W-1:0] {
    KIND_CSR   = 2'b00,
    KIND_ECALL = 2'b01,
    KIND_MRET  = 2'b10,
    KIND_INTR  = 2'b11
  } kind_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  // mstatus / mie / mip bit positions.
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;
  localparam int MIP_MTIP       = 7;

  // Only MIE, MPIE and MPP are writable in mstatus; only MTIE in mie.
  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_1888;
  localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0080;

  // Zicsr update: func3[1:0] = 01 write, 10 set, 11 clear. The imm/reg
  // distinction in func3[2] is resolved upstream into the operand.
  function automatic logic [63:0] csr_apply(input logic [1:0] op,
                                            input logic [63:0] old_val,
                                            input logic [63:0] operand);
    logic [63:0] result;
    case (op)
      2'b01:   result = operand;
      2'b10:   result = old_val | operand;
      2'b11:   result = old_val & ~operand;
      default: result = old_val;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/ysyx_22041412_csr_if.sv
// EXU <-> CSR file request/response bundle.
//   master (EXU): drives valid_i, kind_i, func3_i, addr_i, wdata_i, pc_i
//   slave (CSR file): drives ready_o, rdata_o, redirect_o, target_o, illegal_o
interface ysyx_22041412_csr_if
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int XLEN = 64
);
  logic              valid_i;
  logic              ready_o;
  logic [KIND_W-1:0] kind_i;
  logic [2:0]        func3_i;
  logic [11:0]       addr_i;
  logic [XLEN-1:0]   wdata_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   rdata_o;
  logic              redirect_o;
  logic [XLEN-1:0]   target_o;
  logic              illegal_o;

  modport master (
    output valid_i, kind_i, func3_i, addr_i, wdata_i, pc_i,
    input  ready_o, rdata_o, redirect_o, target_o, illegal_o
  );

  modport slave (
    input  valid_i, kind_i, func3_i, addr_i, wdata_i, pc_i,
    output ready_o, rdata_o, redirect_o, target_o, illegal_o
  );
endinterface

// File: rtl/ysyx_22041412_csr_counter.sv
// 64-bit free-running counter with increment enable and write override.
//   clk, rst : clock, synchronous active-high reset (clears to 0)
//   inc      : add one this cycle
//   we/wdata : load wdata this cycle; takes priority over inc
//   value    : current count, wraps at 2^64
module ysyx_22041412_csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we,
  input  logic [63:0] wdata,
  output logic [63:0] value
);
  logic [63:0] value_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_reg <= '0;
    end else if (we) begin
      value_reg <= wdata;
    end else if (inc) begin
      value_reg <= value_reg + 64'd1;
    end
  end

  assign value = value_reg;
endmodule

// File: rtl/ysyx_22041412_csr_file.sv
// Machine-mode CSR file and trap unit.
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : EXU request (kind/func3/addr/wdata/pc) and one-cycle
//                   response (ready/rdata/redirect/target/illegal)
//   retire_i      : instruction retired, advances minstret
//   timer_irq_i   : machine timer interrupt level, mirrored in mip.MTIP
//   irq_pending_o : mstatus.MIE & mie.MTIE & mip.MTIP
// A request is accepted in IDLE; all CSR state commits on that edge and the
// response is presented from registers during the following RESP cycle.
module ysyx_22041412_csr_file
  import ysyx_22041412_csr_pkg::*;
#(
  parameter int          XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'ha00001800,
  parameter logic [63:0] MTVEC_RST   = 64'h0,
  parameter logic [63:0] HART_ID     = 64'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22041412_csr_if.slave     bus,
  input  logic                   retire_i,
  input  logic                   timer_irq_i,
  output logic                   irq_pending_o
);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e          state_reg;
  logic            ready_reg, redirect_reg, illegal_reg;
  logic [XLEN-1:0] rdata_reg, target_reg;

  logic [XLEN-1:0] mstatus_reg, mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;

  kind_e           kind;
  logic            accept, mapped, read_only, do_write, illegal, csr_we;
  logic            irq_pending, trap_take, mret_take;
  logic [XLEN-1:0] old_val, new_val, trap_cause, mstatus_trap, mstatus_mret;

  // Counters: index 0 = mcycle, 1 = minstret.
  localparam logic [11:0] CNT_ADDR [2] = '{CSR_MCYCLE, CSR_MINSTRET};
  logic [63:0] cnt_val   [2];
  logic [63:0] cnt_wdata [2];
  logic        cnt_we    [2];
  logic        cnt_inc   [2];

  assign cnt_inc[0] = 1'b1;
  assign cnt_inc[1] = retire_i;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    assign cnt_we[gi] = csr_we && (bus.addr_i == CNT_ADDR[gi]);
    // With XLEN=32 a CSR write only replaces the low half of the counter.
    if (XLEN == 64) begin : g_full
      assign cnt_wdata[gi] = 64'(new_val);
    end else begin : g_half
      assign cnt_wdata[gi] = {cnt_val[gi][63:XLEN], new_val};
    end
    ysyx_22041412_csr_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (cnt_inc[gi]),
      .we    (cnt_we[gi]),
      .wdata (cnt_wdata[gi]),
      .value (cnt_val[gi])
    );
  end

  assign kind        = kind_e'(bus.kind_i);
  assign accept      = (state_reg == S_IDLE) && bus.valid_i;
  assign irq_pending = mstatus_reg[MSTATUS_MIE] & mie_reg[MIE_MTIE] & timer_irq_i;

  // Read mux and address decode.
  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (bus.addr_i)
      CSR_MSTATUS:  old_val = mstatus_reg;
      CSR_MIE:      old_val = mie_reg;
      CSR_MTVEC:    old_val = mtvec_reg;
      CSR_MSCRATCH: old_val = mscratch_reg;
      CSR_MEPC:     old_val = mepc_reg;
      CSR_MCAUSE:   old_val = mcause_reg;
      CSR_MIP: begin
        old_val   = XLEN'(timer_irq_i) << MIP_MTIP;
        read_only = 1'b1;
      end
      CSR_MCYCLE:   old_val = cnt_val[0][XLEN-1:0];
      CSR_MINSTRET: old_val = cnt_val[1][XLEN-1:0];
      CSR_MHARTID: begin
        old_val   = XLEN'(HART_ID);
        read_only = 1'b1;
      end
      default:      mapped = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and therefore legal on
  // read-only CSRs.
  assign do_write = (bus.func3_i[1:0] == 2'b01) ||
                    (bus.func3_i[1] && (bus.wdata_i != '0));
  assign illegal  = !mapped ||
                    (do_write && (read_only || (bus.addr_i[11:10] == 2'b11)));
  assign new_val  = XLEN'(csr_apply(bus.func3_i[1:0], 64'(old_val), 64'(bus.wdata_i)));
  assign csr_we   = accept && (kind == KIND_CSR) && !illegal && do_write;

  // An interrupt take with nothing pending degenerates to a no-op.
  assign trap_take  = accept && ((kind == KIND_ECALL) || ((kind == KIND_INTR) && irq_pending));
  assign mret_take  = accept && (kind == KIND_MRET);
  assign trap_cause = (kind == KIND_INTR) ? {1'b1, (XLEN-1)'(CAUSE_MTIMER)}
                                          : XLEN'(CAUSE_ECALL_M);

  always_comb begin
    mstatus_trap                                = mstatus_reg;
    mstatus_trap[MSTATUS_MPIE]                  = mstatus_reg[MSTATUS_MIE];
    mstatus_trap[MSTATUS_MIE]                   = 1'b0;
    mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_mret                                = mstatus_reg;
    mstatus_mret[MSTATUS_MIE]                   = mstatus_reg[MSTATUS_MPIE];
    mstatus_mret[MSTATUS_MPIE]                  = 1'b1;
  end

  // CSR state; everything commits on the accept edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_reg  <= XLEN'(MSTATUS_RST);
      mie_reg      <= '0;
      mtvec_reg    <= XLEN'(MTVEC_RST);
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (trap_take) begin
      mepc_reg     <= bus.pc_i & ALIGN_MASK;
      mcause_reg   <= trap_cause;
      mstatus_reg  <= mstatus_trap;
    end else if (mret_take) begin
      mstatus_reg  <= mstatus_mret;
    end else if (csr_we) begin
      case (bus.addr_i)
        CSR_MSTATUS:  mstatus_reg  <= (mstatus_reg & ~XLEN'(MSTATUS_WMASK)) |
                                      (new_val & XLEN'(MSTATUS_WMASK));
        CSR_MIE:      mie_reg      <= new_val & XLEN'(MIE_WMASK);
        CSR_MTVEC:    mtvec_reg    <= new_val & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_reg <= new_val;
        CSR_MEPC:     mepc_reg     <= new_val & ALIGN_MASK;
        CSR_MCAUSE:   mcause_reg   <= new_val;
        default: ;
      endcase
    end
  end

  // Handshake FSM with registered response; outputs are zero outside RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ready_reg    <= 1'b0;
      rdata_reg    <= '0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
      illegal_reg  <= 1'b0;
    end else begin
      ready_reg    <= 1'b0;
      rdata_reg    <= '0;
      redirect_reg <= 1'b0;
      target_reg   <= '0;
      illegal_reg  <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (bus.valid_i) begin
            state_reg <= S_RESP;
            ready_reg <= 1'b1;
            case (kind)
              KIND_CSR: begin
                illegal_reg <= illegal;
                rdata_reg   <= illegal ? '0 : old_val;
              end
              KIND_ECALL: begin
                redirect_reg <= 1'b1;
                target_reg   <= mtvec_reg;
              end
              KIND_INTR: begin
                redirect_reg <= irq_pending;
                target_reg   <= irq_pending ? mtvec_reg : '0;
              end
              KIND_MRET: begin
                redirect_reg <= 1'b1;
                target_reg   <= mepc_reg;
              end
              default: ;
            endcase
          end
        end
        S_RESP:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_o    = ready_reg;
  assign bus.rdata_o    = rdata_reg;
  assign bus.redirect_o = redirect_reg;
  assign bus.target_o   = target_reg;
  assign bus.illegal_o  = illegal_reg;
  assign irq_pending_o  = irq_pending;
endmodule

// File: doc/ysyx_22041412_csr_file.md
# ysyx_22041412_csr_file

Parametrised machine-mode CSR file and trap unit for the NPC core, successor of the 6-entry CSR block. Decodes full 12-bit CSR addresses, executes Zicsr read-modify-write ops, performs ecall/mret/timer-interrupt trap entry and exit, and keeps free-running mcycle/minstret counters. Sits beside the EXU and talks to it over a valid/ready handshake; on traps it returns a redirect target to the IFU.

## Interface
- XLEN, 64, data/CSR width (32 or 64)
- MSTATUS_RST, 64'ha00001800, mstatus reset value (truncated to XLEN)
- MTVEC_RST, 0, mtvec reset value
- HART_ID, 0, value read from mhartid
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  request valid
- ready_o  out  1  one-cycle response strobe
- kind_i  in  2  00 CSR op, 01 ecall, 10 mret, 11 interrupt take
- func3_i  in  3  Zicsr funct3 (001/101 write, 010/110 set, 011/111 clear)
- addr_i  in  12  CSR address
- wdata_i  in  XLEN  operand (rs1 value or zero-extended uimm)
- pc_i  in  XLEN  PC of requesting instruction
- retire_i  in  1  instruction retired this cycle
- timer_irq_i  in  1  machine timer interrupt level
- rdata_o  out  XLEN  old CSR value (CSR op)
- redirect_o  out  1  target_o valid (ecall/mret/interrupt)
- target_o  out  XLEN  next PC
- illegal_o  out  1  illegal CSR access
- irq_pending_o  out  1  mstatus.MIE & mie.MTIE & mip.MTIP

## Operation
- CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (RO), mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (RO).
- mstatus writable bits: MIE[3], MPIE[7], MPP[12:11]; others hold reset value. mie writable bit MTIE[7] only. mtvec[1:0], mepc[1:0] forced 0. mip bit 7 = timer_irq_i, rest 0.
- CSR op: rdata_o = old value; new = wdata_i / old|wdata_i / old&~wdata_i. Set/clear with wdata_i==0 performs no write and never flags illegal.
- Illegal: unmapped address, or any write attempt to RO CSR / addr[11:10]==2'b11. Illegal -> no state change, rdata_o=0, illegal_o=1.
- ecall: mepc<=pc_i, mcause<=11, MPIE<=MIE, MIE<=0, MPP<=2'b11, target_o=mtvec.
- interrupt: same as ecall but mcause<={1'b1, 7}. Requested only while irq_pending_o=1; otherwise treated as no-op (ready_o, redirect_o=0).
- mret: MIE<=MPIE, MPIE<=1, target_o=mepc.
- mcycle +1 every cycle; minstret +1 when retire_i. CSR write to a counter wins over increment that cycle. Both wrap at 2^64 (64-bit regardless of XLEN; XLEN=32 exposes low half only).

## Timing
- FSM: IDLE -> RESP when valid_i in IDLE (request latched, CSR state updated on that edge); RESP -> IDLE unconditionally. Throughput one request per 2 cycles.
- ready_o, rdata_o, redirect_o, target_o, illegal_o valid only in RESP; all 0 otherwise.
- valid_i in RESP is ignored; requester drops it once ready_o seen, re-asserts for next request.
- Trap target computed from CSR values before the update (mret reads old mepc).
- irq_pending_o combinational from current state.
- Reset: state IDLE, all outputs 0, mstatus=MSTATUS_RST, mtvec=MTVEC_RST, all other CSRs and counters 0. rst in RESP aborts the response; latched write discarded only if not yet committed (writes commit at accept edge, so none lost).

## Structure
- Package ysyx_22041412_csr_pkg: CSR address constants, cause codes, kind_i encoding, mstatus bit indices/write mask.
- Sub-module ysyx_22041412_csr_counter: 64-bit counter with increment enable and write-override, instantiated for mcycle and minstret.

## Test plan
- Reset, then CSR op 0x300 read-set wdata 0 -> ready_o one cycle after valid, rdata_o=0xa00001800, illegal_o=0.
- csrrw 0x305 wdata 0x80000103 then read -> rdata 0x80000100.
- mtvec=0x80000100, ecall pc 0x80000040 -> redirect_o=1, target 0x80000100; mepc=0x80000040, mcause=11, MIE=0, MPIE=old MIE.
- mstatus.MIE=1, mie=0x80, timer_irq_i=1 -> irq_pending_o=1; interrupt take -> mcause=0x8000000000000007; mret -> target=mepc, MIE=1.
- Write to 0xF14 or 0x7C0 -> illegal_o=1, no state change; csrrs 0xF14 wdata 0 -> rdata HART_ID, no illegal.
- Write mcycle=0xFFFFFFFFFFFFFFFF -> next cycle reads 0 (wrap); reset asserted in RESP -> ready_o 0 next cycle.
